// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized line, falling-edge start detect, mid-bit sampling.
// Emits a one-cycle rx_done with the received byte, or a one-cycle frame_err on a low stop bit.
module uart_rx #(
   parameter int BAUD_CNT_MAX = 5207
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam logic [13:0] HALF_CNT = 14'(BAUD_CNT_MAX / 2);
   localparam logic [13:0] FULL_CNT = 14'(BAUD_CNT_MAX - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state;
   logic [13:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        sync1;
   logic        sync2;
   logic        hist;
   logic        fall;

   // Edge is taken from the synchronized line against its one-cycle history.
   assign fall    = hist & ~sync2;
   assign rx_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         hist  <= 1'b1;
      end else begin
         sync1 <= rx_in;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
               if (fall) begin
                  state <= START;
               end
            end
            START: begin
               if (baud_cnt == HALF_CNT) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  // A high line at mid start bit was only a glitch.
                  state    <= sync2 ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + 14'd1;
               end
            end
            DATA: begin
               if (baud_cnt == FULL_CNT) begin
                  baud_cnt       <= '0;
                  shift[bit_idx] <= sync2;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 14'd1;
               end
            end
            STOP: begin
               if (baud_cnt == FULL_CNT) begin
                  baud_cnt <= '0;
                  // Leave mid stop bit so a directly following start edge is seen.
                  state    <= IDLE;
                  if (sync2) begin
                     rx_data <= shift;
                     rx_done <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 14'd1;
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with 16 clocks per bit; a negedge monitor tallies output pulses
// and each scenario task compares tallies and rx_data against hand-computed values.
module tb_uart_rx;

   logic       clk;
   logic       reset;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       rx_busy;

   int checks;
   int failures;

   int         done_total;
   int         err_total;
   int         busy_total;
   int         both_total;
   logic [7:0] data_q[$];

   uart_rx #(.BAUD_CNT_MAX(16)) dut (
      .clk(clk),
      .reset(reset),
      .rx_in(rx_in),
      .rx_data(rx_data),
      .rx_done(rx_done),
      .frame_err(frame_err),
      .rx_busy(rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_done) begin
         done_total = done_total + 1;
         data_q.push_back(rx_data);
      end
      if (frame_err) err_total = err_total + 1;
      if (rx_busy) busy_total = busy_total + 1;
      if (rx_done && frame_err) both_total = both_total + 1;
   end

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx_in = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (16) @(negedge clk);
      end
      rx_in = stop;
      repeat (16) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rx_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_rx_data got=%h want=00", rx_data);
      end
      checks++;
      if (rx_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_rx_done got=%b want=0", rx_done);
      end
      checks++;
      if (frame_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_frame_err got=%b want=0", frame_err);
      end
      checks++;
      if (rx_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_rx_busy got=%b want=0", rx_busy);
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      $display("reset: rx_data=%h busy=%b", rx_data, rx_busy);
   endtask

   task automatic test_single;
      int d0, e0, q0;
      d0 = done_total; e0 = err_total; q0 = data_q.size();
      send_frame(8'hA5, 1'b1);
      repeat (32) @(negedge clk);
      checks++;
      if (done_total - d0 !== 1) begin
         failures++;
         $display("FAIL single_done_count got=%0d want=1", done_total - d0);
      end
      checks++;
      if (err_total - e0 !== 0) begin
         failures++;
         $display("FAIL single_err_count got=%0d want=0", err_total - e0);
      end
      checks++;
      if (data_q.size() <= q0 || data_q[q0] !== 8'hA5) begin
         failures++;
         $display("FAIL single_data_at_done got=%h want=a5", (data_q.size() > q0) ? data_q[q0] : 8'hxx);
      end
      checks++;
      if (rx_data !== 8'hA5) begin
         failures++;
         $display("FAIL single_rx_data_hold got=%h want=a5", rx_data);
      end
      $display("single: frame a5 rx_data=%h", rx_data);
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp[3];
      int d0, q0;
      exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
      d0 = done_total; q0 = data_q.size();
      for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
      repeat (32) @(negedge clk);
      checks++;
      if (done_total - d0 !== 3) begin
         failures++;
         $display("FAIL b2b_done_count got=%0d want=3", done_total - d0);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (data_q.size() <= q0 + i || data_q[q0 + i] !== exp[i]) begin
            failures++;
            $display("FAIL b2b_data_%0d got=%h want=%h", i,
                     (data_q.size() > q0 + i) ? data_q[q0 + i] : 8'hxx, exp[i]);
         end
         $display("b2b: frame %0d expected=%h", i, exp[i]);
      end
   endtask

   task automatic test_glitch;
      int d0, e0, b0;
      d0 = done_total; e0 = err_total; b0 = busy_total;
      rx_in = 1'b0;
      repeat (4) @(negedge clk);
      rx_in = 1'b1;
      repeat (40) @(negedge clk);
      // START lasts for counter values 0..8, i.e. 9 cycles, then returns to IDLE.
      checks++;
      if (busy_total - b0 !== 9) begin
         failures++;
         $display("FAIL glitch_busy_cycles got=%0d want=9", busy_total - b0);
      end
      checks++;
      if (rx_busy !== 1'b0) begin
         failures++;
         $display("FAIL glitch_busy_after got=%b want=0", rx_busy);
      end
      checks++;
      if (done_total - d0 !== 0 || err_total - e0 !== 0) begin
         failures++;
         $display("FAIL glitch_pulses got=done%0d/err%0d want=0/0", done_total - d0, err_total - e0);
      end
      $display("glitch: busy cycles=%0d", busy_total - b0);
   endtask

   task automatic test_frame_error;
      int d0, e0;
      send_frame(8'h5A, 1'b1);
      repeat (32) @(negedge clk);
      checks++;
      if (rx_data !== 8'h5A) begin
         failures++;
         $display("FAIL ferr_pre_data got=%h want=5a", rx_data);
      end
      d0 = done_total; e0 = err_total;
      send_frame(8'h81, 1'b0);
      repeat (640) @(negedge clk);
      checks++;
      if (err_total - e0 !== 1) begin
         failures++;
         $display("FAIL ferr_err_count got=%0d want=1", err_total - e0);
      end
      checks++;
      if (done_total - d0 !== 0) begin
         failures++;
         $display("FAIL ferr_done_count got=%0d want=0", done_total - d0);
      end
      checks++;
      if (rx_data !== 8'h5A) begin
         failures++;
         $display("FAIL ferr_data_hold got=%h want=5a", rx_data);
      end
      $display("frame_err: frame 81 low stop, rx_data=%h", rx_data);
      rx_in = 1'b1;
      repeat (32) @(negedge clk);
      send_frame(8'h42, 1'b1);
      repeat (32) @(negedge clk);
      checks++;
      if (done_total - d0 !== 1 || err_total - e0 !== 1) begin
         failures++;
         $display("FAIL recover_counts got=done%0d/err%0d want=1/1", done_total - d0, err_total - e0);
      end
      checks++;
      if (rx_data !== 8'h42) begin
         failures++;
         $display("FAIL recover_data got=%h want=42", rx_data);
      end
      $display("recover: frame 42 rx_data=%h", rx_data);
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] b;
      int d0, e0;
      b = 8'hF3;
      d0 = done_total; e0 = err_total;
      rx_in = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_in = b[i];
         repeat (16) @(negedge clk);
      end
      rx_in = b[4];
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (rx_data !== 8'h00 || rx_busy !== 1'b0 || rx_done !== 1'b0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL midreset_outputs got=data%h/busy%b/done%b/err%b want=00/0/0/0",
                  rx_data, rx_busy, rx_done, frame_err);
      end
      // Bits 4..7 and the stop bit are all high, so the line stays quiet after reset.
      repeat (8 + 48 + 16 + 32) @(negedge clk);
      checks++;
      if (done_total - d0 !== 0 || err_total - e0 !== 0) begin
         failures++;
         $display("FAIL midreset_pulses got=done%0d/err%0d want=0/0", done_total - d0, err_total - e0);
      end
      send_frame(8'h99, 1'b1);
      repeat (32) @(negedge clk);
      checks++;
      if (rx_data !== 8'h99 || done_total - d0 !== 1) begin
         failures++;
         $display("FAIL midreset_next got=data%h/done%0d want=99/1", rx_data, done_total - d0);
      end
      $display("midreset: next frame 99 rx_data=%h", rx_data);
   endtask

   initial begin
      checks = 0; failures = 0;
      done_total = 0; err_total = 0; busy_total = 0; both_total = 0;
      reset = 1'b1;
      rx_in = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_reset_mid_frame();
      checks++;
      if (both_total !== 0) begin
         failures++;
         $display("FAIL done_and_err_same_cycle got=%0d want=0", both_total);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_CNT_MAX, default 5207, meaning clock cycles per UART bit (9600 baud at 50 MHz); legal range 4..16383.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 rx_in  input  1  asynchronous serial line; idles high; 8N1, LSB first.
REQ-005 rx_data  output  8  last correctly framed byte; holds until the next good frame.
REQ-006 rx_done  output  1  one-cycle pulse; rx_data is valid in the same cycle.
REQ-007 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 rx_busy  output  1  high in any state other than IDLE.

Function
REQ-009 rx_in SHALL pass through a 2-flop synchronizer, then one further history flop; all three flops reset to 1.
REQ-010 Falling edge SHALL be defined as history flop = 1 and synchronized value = 0; a line held low SHALL NOT generate repeated edges.
REQ-011 FSM states SHALL be IDLE, START, DATA and STOP; reset state is IDLE.
REQ-012 14-bit baud counter SHALL be 0 in IDLE and increment once per cycle in the other states.
REQ-013 In each non-IDLE state the counter SHALL clear to 0 on the cycle a sample is taken.
REQ-014 IDLE -> START on a falling edge; the counter starts at 0 on the next cycle.
REQ-015 START SHALL sample the line when the counter equals BAUD_CNT_MAX/2 (integer division), i.e. mid start bit.
REQ-016 If that start-bit sample is 1, the FSM SHALL return to IDLE (glitch reject) with no output pulse.
REQ-017 If that start-bit sample is 0, the FSM SHALL go to DATA with bit index 0.
REQ-018 DATA SHALL sample the line when the counter equals BAUD_CNT_MAX-1.
REQ-019 Each DATA sample SHALL be stored into shift-register bit [bit index] (LSB first), after which the 3-bit bit index increments.
REQ-020 After the sample at bit index 7, the FSM SHALL go to STOP.
REQ-021 STOP SHALL sample the line when the counter equals BAUD_CNT_MAX-1.
REQ-022 Stop sample = 1: on the next cycle rx_data SHALL load the shift register and rx_done SHALL pulse for exactly 1 cycle.
REQ-023 Stop sample = 0: frame_err SHALL pulse for exactly 1 cycle and rx_data SHALL be unchanged.
REQ-024 After the STOP sample the FSM SHALL return to IDLE immediately (mid stop bit), so back-to-back frames with a single stop bit are received.
REQ-025 rx_done and frame_err SHALL never be asserted in the same cycle.
REQ-026 Falling edges that occur while rx_busy = 1 SHALL be ignored.
REQ-027 The shift register SHALL be internal; rx_data SHALL change only on a good frame.

Reset
REQ-028 reset = 1 SHALL, on the next clock edge, force the following state from any state, including mid-frame:
- FSM = IDLE; counter = 0; bit index = 0; shift register = 0x00
- rx_data = 0x00; rx_done = 0; frame_err = 0; rx_busy = 0
- all three synchronizer/history flops = 1
REQ-029 A frame interrupted by reset SHALL produce no rx_done and no frame_err pulse.
REQ-030 A frame whose start edge occurs after reset deasserts SHALL be received normally.

Verification (BAUD_CNT_MAX = 16 unless noted)
REQ-031 Frame 0xA5 with a good stop bit -> exactly one rx_done pulse, rx_data = 0xA5, frame_err = 0 throughout.
REQ-032 Frames 0x00, 0xFF, 0x3C sent back-to-back with 1 stop bit each -> three rx_done pulses, with rx_data = 0x00, 0xFF, 0x3C in that order.
REQ-033 rx_in low for 4 cycles, then high -> FSM returns to IDLE after the start-bit sample; no rx_done, no frame_err; rx_busy pulses high, then low.
REQ-034 0x5A is received first, then frame 0x81 is sent with its stop bit driven low -> one frame_err pulse, no rx_done, rx_data stays 0x5A.
REQ-035 Line held low for 40 bit times after a framing error -> no further output pulses; after the line returns high, frame 0x42 -> rx_done, rx_data = 0x42.
REQ-036 reset asserted for 1 cycle during data bit 4 of a frame -> outputs match REQ-028 next cycle, no pulse for that frame; next frame 0x99 -> rx_data = 0x99.
